// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU and its two-port arbiter: op codes, the
// highest defined op code and the port identifiers.
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_AND    = 4'd2;
   localparam logic [3:0] ALU_OR     = 4'd3;
   localparam logic [3:0] ALU_SLL    = 4'd4;
   localparam logic [3:0] ALU_SLTU   = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_XOR    = 4'd8;
   localparam logic [3:0] ALU_OP_MAX = 4'd8;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   function automatic logic op_defined(input logic [3:0] ctrl);
      return (ctrl <= ALU_OP_MAX);
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// ---------------------------------------------------------------------------
// alu_arbiter_alu
// Single-cycle combinational integer ALU shared by the arbiter.
// Ports:
//   ctrl   in  4  : op code (alu_pkg::ALU_*)
//   a, b   in  32 : operands
//   result out 32 : combinational result; 0 for undefined op codes
// ---------------------------------------------------------------------------
module alu_arbiter_alu
   import alu_pkg::*;
(
   input  logic [3:0]  ctrl,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result
);

   always_comb begin
      result = '0;
      unique case (ctrl)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_SLL:  result = a << b[4:0];
         ALU_SLTU: result = {31'd0, (a < b)};
         ALU_SRL:  result = a >> b[4:0];
         ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
         ALU_XOR:  result = a ^ b;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one single-cycle ALU between port 0 (execute) and port 1 (aux
// address/branch). At most one grant per cycle; the response is registered
// and returned to the granted port one cycle later.
// Parameters:
//   FIXED_PRIO   : 0 round-robin, 1 port 0 priority with port 1 starve guard
//   STARVE_LIMIT : cycles port 1 may wait in fixed mode (1..15)
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   reqN_valid/a/b/ctrl        : request from port N
//   reqN_ready                 : combinational grant to port N
//   rspN_valid/result/zf/err   : registered response to port N
//   busy                       : an operation was granted last cycle
// ---------------------------------------------------------------------------
module alu_arbiter
   import alu_pkg::*;
#(
   parameter bit          FIXED_PRIO   = 1'b0,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        req0_valid,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [3:0]  req0_ctrl,
   output logic        req0_ready,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_result,
   output logic        rsp0_zf,
   output logic        rsp0_err,

   input  logic        req1_valid,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [3:0]  req1_ctrl,
   output logic        req1_ready,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_result,
   output logic        rsp1_zf,
   output logic        rsp1_err,

   output logic        busy
);

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic        last_grant;
   logic [3:0]  starve_cnt;
   logic        gnt0;
   logic        gnt1;

   logic [3:0]  alu_ctrl;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic        op_err;

   // Grants are built from valids and arbiter state only, so neither ready
   // feeds the other.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (FIXED_PRIO) begin
         if (req1_valid && (!req0_valid || starve_cnt == STARVE_MAX)) begin
            gnt1 = 1'b1;
         end else begin
            gnt0 = req0_valid;
         end
      end else begin
         if (req0_valid && req1_valid) begin
            if (last_grant == PORT0) begin
               gnt1 = 1'b1;
            end else begin
               gnt0 = 1'b1;
            end
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // Idle cycles and undefined op codes both park the ALU on ADD 0+0.
   always_comb begin
      alu_ctrl = ALU_ADD;
      alu_a    = '0;
      alu_b    = '0;
      op_err   = 1'b0;
      if (gnt0) begin
         if (op_defined(req0_ctrl)) begin
            alu_ctrl = req0_ctrl;
            alu_a    = req0_a;
            alu_b    = req0_b;
         end else begin
            op_err   = 1'b1;
         end
      end else if (gnt1) begin
         if (op_defined(req1_ctrl)) begin
            alu_ctrl = req1_ctrl;
            alu_a    = req1_a;
            alu_b    = req1_b;
         end else begin
            op_err   = 1'b1;
         end
      end
   end

   alu_arbiter_alu u_alu (
      .ctrl   (alu_ctrl),
      .a      (alu_a),
      .b      (alu_b),
      .result (alu_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant  <= PORT1;
         starve_cnt  <= '0;
         busy        <= 1'b0;
         rsp0_valid  <= 1'b0;
         rsp0_result <= '0;
         rsp0_zf     <= 1'b0;
         rsp0_err    <= 1'b0;
         rsp1_valid  <= 1'b0;
         rsp1_result <= '0;
         rsp1_zf     <= 1'b0;
         rsp1_err    <= 1'b0;
      end else begin
         busy       <= gnt0 | gnt1;
         rsp0_valid <= gnt0;
         rsp1_valid <= gnt1;

         if (gnt0) begin
            rsp0_result <= alu_result;
            rsp0_zf     <= (alu_result == '0);
            rsp0_err    <= op_err;
            last_grant  <= PORT0;
         end
         if (gnt1) begin
            rsp1_result <= alu_result;
            rsp1_zf     <= (alu_result == '0);
            rsp1_err    <= op_err;
            last_grant  <= PORT1;
         end

         // Counts cycles port 1 has been left waiting; any transfer or drop
         // of its request restarts the count.
         if (req1_valid && !gnt1) begin
            if (starve_cnt != STARVE_MAX) begin
               starve_cnt <= starve_cnt + 4'd1;
            end
         end else begin
            starve_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

   localparam int LIM = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // index [d][p]: d=0 round-robin instance, d=1 fixed-priority instance
   logic        v    [2][2];
   logic [31:0] a    [2][2];
   logic [31:0] b    [2][2];
   logic [3:0]  op   [2][2];
   wire         rdy  [2][2];
   wire         rv   [2][2];
   wire  [31:0] rres [2][2];
   wire         rzf  [2][2];
   wire         rerr [2][2];
   wire         busy [2];

   alu_arbiter #(.FIXED_PRIO(1'b0), .STARVE_LIMIT(4)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v[0][0]), .req0_a(a[0][0]), .req0_b(b[0][0]), .req0_ctrl(op[0][0]),
      .req0_ready(rdy[0][0]), .rsp0_valid(rv[0][0]), .rsp0_result(rres[0][0]),
      .rsp0_zf(rzf[0][0]), .rsp0_err(rerr[0][0]),
      .req1_valid(v[0][1]), .req1_a(a[0][1]), .req1_b(b[0][1]), .req1_ctrl(op[0][1]),
      .req1_ready(rdy[0][1]), .rsp1_valid(rv[0][1]), .rsp1_result(rres[0][1]),
      .rsp1_zf(rzf[0][1]), .rsp1_err(rerr[0][1]),
      .busy(busy[0])
   );

   alu_arbiter #(.FIXED_PRIO(1'b1), .STARVE_LIMIT(LIM)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v[1][0]), .req0_a(a[1][0]), .req0_b(b[1][0]), .req0_ctrl(op[1][0]),
      .req0_ready(rdy[1][0]), .rsp0_valid(rv[1][0]), .rsp0_result(rres[1][0]),
      .rsp0_zf(rzf[1][0]), .rsp0_err(rerr[1][0]),
      .req1_valid(v[1][1]), .req1_a(a[1][1]), .req1_b(b[1][1]), .req1_ctrl(op[1][1]),
      .req1_ready(rdy[1][1]), .rsp1_valid(rv[1][1]), .rsp1_result(rres[1][1]),
      .rsp1_zf(rzf[1][1]), .rsp1_err(rerr[1][1]),
      .busy(busy[1])
   );

   // reference model state
   int          m_last;
   int          m_wait;
   logic [31:0] e_res [2][2];
   logic        e_zf  [2][2];
   logic        e_err [2][2];
   int          g_prev[2];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] x,
                                           input logic [31:0] y);
      logic [31:0] r;
      case (int'(c))
         0: r = x + y;
         1: r = x - y;
         2: r = x & y;
         3: r = x | y;
         4: r = x << y[4:0];
         5: r = (x < y) ? 32'd1 : 32'd0;
         6: r = x >> y[4:0];
         7: r = $unsigned($signed(x) >>> y[4:0]);
         8: r = x ^ y;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   function automatic int model_grant(input int d);
      if (d == 0) begin
         if (v[0][0] && v[0][1]) return (m_last == 0) ? 1 : 0;
         if (v[0][0]) return 0;
         if (v[0][1]) return 1;
         return -1;
      end
      if (v[1][1] && (!v[1][0] || m_wait >= LIM)) return 1;
      if (v[1][0]) return 0;
      return -1;
   endfunction

   task automatic model_reset();
      m_last = 1;
      m_wait = 0;
      for (int d = 0; d < 2; d++) begin
         g_prev[d] = -1;
         for (int p = 0; p < 2; p++) begin
            e_res[d][p] = '0;
            e_zf[d][p]  = 1'b0;
            e_err[d][p] = 1'b0;
         end
      end
   endtask

   task automatic idle_all();
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) begin
            v[d][p] = 1'b0; a[d][p] = '0; b[d][p] = '0; op[d][p] = '0;
         end
   endtask

   // One clock: check grants mid-cycle, then responses just after the edge.
   task automatic step();
      int g[2];
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         g[d] = model_grant(d);
         chk($sformatf("d%0d ready0", d), 32'(rdy[d][0]), 32'(g[d] == 0));
         chk($sformatf("d%0d ready1", d), 32'(rdy[d][1]), 32'(g[d] == 1));
         if (g[d] >= 0) begin
            e_res[d][g[d]] = ref_alu(op[d][g[d]], a[d][g[d]], b[d][g[d]]);
            e_err[d][g[d]] = (op[d][g[d]] > 4'd8);
            e_zf[d][g[d]]  = (e_res[d][g[d]] == 32'd0);
         end
      end
      if (g[0] >= 0 && op[0][g[0]] <= 4'd8) begin
         chk("alu ctrl", 32'(u_rr.alu_ctrl), 32'(op[0][g[0]]));
         chk("alu a", u_rr.alu_a, a[0][g[0]]);
         chk("alu b", u_rr.alu_b, b[0][g[0]]);
      end else begin
         chk("alu ctrl parked", 32'(u_rr.alu_ctrl), 32'd0);
         chk("alu a parked", u_rr.alu_a, 32'd0);
         chk("alu b parked", u_rr.alu_b, 32'd0);
      end
      if (g[0] >= 0) m_last = g[0];
      if (v[1][1] && g[1] != 1) m_wait = (m_wait < LIM) ? m_wait + 1 : LIM;
      else m_wait = 0;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("d%0d rsp%0d valid", d, p), 32'(rv[d][p]), 32'(g[d] == p));
            chk($sformatf("d%0d rsp%0d result", d, p), rres[d][p], e_res[d][p]);
            chk($sformatf("d%0d rsp%0d zf", d, p), 32'(rzf[d][p]), 32'(e_zf[d][p]));
            chk($sformatf("d%0d rsp%0d err", d, p), 32'(rerr[d][p]), 32'(e_err[d][p]));
         end
         chk($sformatf("d%0d busy", d), 32'(busy[d]), 32'(g[d] >= 0));
      end
      g_prev = g;
   endtask

   task automatic check_all_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s d%0d rv%0d", tag, d, p), 32'(rv[d][p]), 32'd0);
            chk($sformatf("%s d%0d res%0d", tag, d, p), rres[d][p], 32'd0);
            chk($sformatf("%s d%0d zf%0d", tag, d, p), 32'(rzf[d][p]), 32'd0);
            chk($sformatf("%s d%0d err%0d", tag, d, p), 32'(rerr[d][p]), 32'd0);
         end
         chk($sformatf("%s d%0d busy", tag, d), 32'(busy[d]), 32'd0);
      end
      chk($sformatf("%s starve_cnt", tag), 32'(u_fp.starve_cnt), 32'd0);
   endtask

   initial begin
      int seq_rr[4];
      int seq_fp[8];
      int exp_rr[4];
      int exp_fp[8];
      exp_rr = '{0, 1, 0, 1};
      exp_fp = '{0, 0, 0, 1, 0, 0, 0, 1};

      idle_all();
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single request, port 0 ADD 5+7
      v[0][0] = 1'b1; op[0][0] = 4'd0; a[0][0] = 32'd5; b[0][0] = 32'd7;
      step();
      chk("single rsp0 valid", 32'(rv[0][0]), 32'd1);
      chk("single result", rres[0][0], 32'd12);
      chk("single zf", 32'(rzf[0][0]), 32'd0);
      chk("single err", 32'(rerr[0][0]), 32'd0);
      chk("single rsp1 quiet", 32'(rv[0][1]), 32'd0);
      v[0][0] = 1'b0;

      // port 1 SUB to zero, then SLTU
      v[0][1] = 1'b1; op[0][1] = 4'd1; a[0][1] = 32'd9; b[0][1] = 32'd9;
      step();
      chk("sub result", rres[0][1], 32'd0);
      chk("sub zf", 32'(rzf[0][1]), 32'd1);
      op[0][1] = 4'd5; a[0][1] = 32'd1; b[0][1] = 32'hFFFF_FFFF;
      step();
      chk("sltu result", rres[0][1], 32'd1);
      chk("sltu zf", 32'(rzf[0][1]), 32'd0);
      v[0][1] = 1'b0;

      // round-robin contention
      for (int i = 0; i < 4; i++) begin
         for (int p = 0; p < 2; p++) begin
            v[0][p] = 1'b1; op[0][p] = 4'(p + i); a[0][p] = $urandom; b[0][p] = 32'(i + 1);
         end
         step();
         seq_rr[i] = g_prev[0];
      end
      for (int i = 0; i < 4; i++) chk($sformatf("rr grant %0d", i), 32'(seq_rr[i]), 32'(exp_rr[i]));
      v[0][0] = 1'b0; v[0][1] = 1'b0;

      // undefined op code
      v[0][0] = 1'b1; op[0][0] = 4'hC; a[0][0] = 32'd3; b[0][0] = 32'd4;
      #1;
      chk("undef alu ctrl", 32'(u_rr.alu_ctrl), 32'd0);
      chk("undef alu a", u_rr.alu_a, 32'd0);
      chk("undef alu b", u_rr.alu_b, 32'd0);
      step();
      chk("undef result", rres[0][0], 32'd0);
      chk("undef zf", 32'(rzf[0][0]), 32'd1);
      chk("undef err", 32'(rerr[0][0]), 32'd1);
      v[0][0] = 1'b0;

      // fixed priority with starvation guard
      for (int i = 0; i < 8; i++) begin
         for (int p = 0; p < 2; p++) begin
            v[1][p] = 1'b1; op[1][p] = 4'd0; a[1][p] = 32'(100 + i); b[1][p] = 32'(p);
         end
         step();
         seq_fp[i] = g_prev[1];
         if (g_prev[1] == 1) chk($sformatf("starve clear %0d", i), 32'(u_fp.starve_cnt), 32'd0);
      end
      for (int i = 0; i < 8; i++) chk($sformatf("fp grant %0d", i), 32'(seq_fp[i]), 32'(exp_fp[i]));
      v[1][0] = 1'b0; v[1][1] = 1'b0;

      // reset while a response is due
      v[0][0] = 1'b1; op[0][0] = 4'd0; a[0][0] = 32'd2; b[0][0] = 32'd3;
      @(negedge clk);
      chk("rst-mid ready", 32'(rdy[0][0]), 32'd1);
      rst_n = 1'b0;
      #1;
      check_all_zero("rst-mid");
      @(posedge clk);
      #1;
      chk("rst-mid rsp0 dropped", 32'(rv[0][0]), 32'd0);
      chk("rst-mid result", rres[0][0], 32'd0);
      @(negedge clk);
      idle_all();
      model_reset();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      v[0][0] = 1'b1; v[0][1] = 1'b1; op[0][0] = 4'd3; op[0][1] = 4'd8;
      a[0][0] = 32'h0F; b[0][0] = 32'hF0; a[0][1] = 32'h55; b[0][1] = 32'hAA;
      step();
      chk("post-reset first grant", 32'(g_prev[0]), 32'd0);

      // randomized traffic on both instances
      for (int c = 0; c < 600; c++) begin
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
               if (!v[d][p] || g_prev[d] == p) begin
                  v[d][p]  = ($urandom_range(0, 3) != 0);
                  op[d][p] = 4'($urandom_range(0, 15));
                  a[d][p]  = $urandom;
                  b[d][p]  = $urandom;
                  if ($urandom_range(0, 7) == 0) b[d][p] = a[d][p];
                  if (op[d][p] == 4'd4 || op[d][p] == 4'd6 || op[d][p] == 4'd7)
                     b[d][p] = b[d][p] & 32'd31;
               end
            end
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle integer ALU between two requesters: port 0 (main execute stage) and port 1 (auxiliary address/branch unit). Each cycle it grants at most one operation, drives the ALU with the granted operands, and returns a registered result, zero flag and error flag to the granted port one cycle later. Policy is round-robin, or fixed priority with a starvation limit.

## Interface
Parameters:
- `FIXED_PRIO`, 0: 0 selects round-robin; 1 selects port 0 priority with a starvation guard for port 1.
- `STARVE_LIMIT`, 4: in fixed-priority mode, consecutive cycles port 1 may wait before it is forced a grant. Range 1..15.

Ports:
- `clk`  in  1: the single clock; all state is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req0_valid`  in  1: port 0 has an operation pending.
- `req0_a`, `req0_b`  in  32: operands.
- `req0_ctrl`  in  4: ALU op code.
- `req0_ready`  out  1: combinational grant to port 0 this cycle.
- `rsp0_valid`  out  1: one-cycle pulse; result for port 0 is valid.
- `rsp0_result`  out  32: registered result.
- `rsp0_zf`  out  1: result is zero.
- `rsp0_err`  out  1: op code was undefined.
- `req1_*`, `rsp1_*`: same as port 0, for port 1.
- `busy`  out  1: registered; an operation was granted in the previous cycle.

## Operation
- Handshake: a transfer occurs when `reqN_valid && reqN_ready`. A requester holds valid and payload stable until ready. Ready never depends on the opposite port's ready.
- At most one grant per cycle. `reqN_ready` is 0 when `reqN_valid` is 0.
- Round-robin grant:
  - With a single requester, that requester is granted.
  - With both requesting, the port not granted last is granted.
  - `last_grant` updates only on a transfer.
- Fixed-priority grant:
  - Port 0 wins unless `starve_cnt == STARVE_LIMIT`; then port 1 wins.
  - `starve_cnt` increments, saturating at the limit, on each cycle port 1 is valid but not granted.
  - `starve_cnt` clears when port 1 transfers or when `req1_valid` is 0.
- Op codes, with constants from the package:
  - ADD=0, SUB=1, AND=2, OR=3, SLL=4, SLTU=5, SRL=6, SRA=7, XOR=8.
  - SLTU is an unsigned compare and gives 1 or 0.
  - Operands reach the ALU unmodified. Shift amount masking is the requester's job.
- Undefined codes (9..15):
  - The ALU is driven with ADD and operands 0.
  - Response is result 0, zf 1, err 1.
- Idle cycles: the ALU control is driven to ADD with operands 0, so the ALU never holds stale state.
- Response regs:
  - On a transfer from port N, the next edge loads `rspN_result`/`zf`/`err` and sets `rspN_valid` to 1 for exactly one cycle.
  - The other port's `rsp` data registers hold their value.
- There is no response backpressure. Requesters must sink `rsp` when it is valid.

## Timing
- Latency: request accepted at edge N produces response valid in cycle N+1 (one register stage).
- Throughput: one operation per cycle total. Back-to-back grants to the same port give consecutive rsp pulses.
- Reset (async assert, sync-safe deassert):
  - `rsp*_valid`=0, `rsp*_result`=0, `rsp*_zf`=0, `rsp*_err`=0.
  - `busy`=0, `starve_cnt`=0.
  - `last_grant`=1, so port 0 wins the first contention.
- Reset mid-operation: a response due on the next edge is dropped. Requesters re-issue after reset.
- Round-robin mode: worst-case wait is 1 cycle.
- Fixed mode: worst-case wait for port 1 is `STARVE_LIMIT` cycles.

## Structure
- Shared package `alu_pkg`:
  - op code localparams `ALU_ADD` … `ALU_XOR`.
  - `ALU_OP_MAX`=8.
  - Port-id constants `PORT0`/`PORT1`.
- One sub-module: the existing `ALU` instance, driven by grant muxes.
- The arbiter is `alu_arbiter` only. Grant logic is combinational; `last_grant`, `starve_cnt`, response and busy registers are sequential.

## Test plan
- Single request: port 0, ctrl=0, a=5, b=7 → `req0_ready`=1 same cycle; next cycle `rsp0_valid`=1, result 12, zf 0, err 0; `rsp1_valid` stays 0.
- Zero and unsigned compare: port 1 SUB a=9, b=9 → result 0, zf 1. Port 1 SLTU a=1, b=0xFFFFFFFF → result 1, zf 0.
- Round-robin contention: both ports valid for 4 cycles after reset → grants 0,1,0,1; responses alternate with 1-cycle latency.
- Fixed priority, `STARVE_LIMIT`=3: both valid continuously → grants 0,0,0,1,0,0,0,1; `starve_cnt` returns to 0 after each port-1 grant.
- Undefined op: port 0 ctrl=4'hC, a=3, b=4 → result 0, zf 1, err 1; ALU inputs observed as ADD with operands 0.
- Reset mid-op: assert `rst_n`=0 in the cycle after a grant → `rsp0_valid` is never asserted and all outputs are 0. After release with both valid, port 0 is granted first.
